// File: rtl/arbitro_rr_sync.sv
// Four-way round-robin arbiter with per-line request synchronizers and grant-until-done hold.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.

module arbitro_rr_sync_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sr <= '0;
      else      sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];
endmodule

module arbitro_rr_sync #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic [1:0] grant_id,
   output logic       busy,
   output logic       timeout
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   logic [1:0] state;
   logic [1:0] ptr;
   logic [3:0] req_s;
   logic [1:0] win;
   logic       win_vld;
   logic [1:0] idx;
   logic       to_hit;

   for (genvar i = 0; i < 4; i++) begin : g_sync
      arbitro_rr_sync_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (req[i]),
         .q   (req_s[i])
      );
   end

   // Search order ptr+1, ptr+2, ptr+3, ptr: the last owner always goes last.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + k[1:0];
         if (!win_vld && req_s[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;

   // done in the limit cycle wins, so the watchdog only fires without it.
   assign to_hit  = (state == S_GRANT) && !done && (cnt == CW'(TIMEOUT_CYCLES));
   assign timeout = to_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    cnt <= '0;
      else if (state != S_GRANT)                   cnt <= '0;
      else if (!done && !to_hit)                   cnt <= cnt + 1'b1;
   end
`else
   logic unused_to_cfg;
   assign unused_to_cfg = (TIMEOUT_CYCLES != 0);
   assign to_hit        = 1'b0;
   assign timeout       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         ptr      <= 2'd3;
         grant    <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  grant    <= 4'b0001 << win;
                  grant_id <= win;
                  busy     <= 1'b1;
                  state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (done || to_hit) begin
                  grant <= '0;
                  busy  <= 1'b0;
                  state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               ptr   <= grant_id;
               state <= S_IDLE;
            end
            default: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_arbitro_rr_sync.sv
// Bench for arbitro_rr_sync: vector table plus hand-written corner sequences; grants are
// scored against a queue of expected winners filled when each request is driven.

module tb_arbitro_rr_sync;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = '0;
   logic       done = 1'b0;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout;

   arbitro_rr_sync #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct { logic [3:0] g; logic [1:0] id; } exp_t;
   typedef struct { logic [3:0] req; logic [3:0] g; logic [1:0] id; } vec_t;

   exp_t       sb[$];
   exp_t       e;
   vec_t       vt[7];
   logic [3:0] prev_g = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_busy(input string name);
      int k;
      k = 0;
      while (!busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(name, busy, 1);
   endtask

   task automatic push(input logic [3:0] g, input logic [1:0] id);
      exp_t x;
      x.g  = g;
      x.id = id;
      sb.push_back(x);
   endtask

   // Drops the request together with done; the synchronizer delay keeps it out of the next IDLE.
   task automatic release_owner(input string name);
      req  = '0;
      done = 1'b1;
      cyc(1);
      done = 1'b0;
      chk({name, "_rel_grant"}, grant, 0);
      chk({name, "_rel_busy"}, busy, 0);
      cyc(3);
   endtask

   // Scoreboard: every new grant must match the oldest expectation.
   always @(negedge clk) begin
      if (grant != 4'b0000 && prev_g == 4'b0000) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got grant %b, want no grant", grant);
         end else begin
            e = sb.pop_front();
            chk("sb_grant", grant, e.g);
            chk("sb_id", grant_id, e.id);
         end
      end
      chk("onehot", ($countones(grant) <= 1), 1);
      prev_g = grant;
   end

   initial begin
      bit hold_ok;
      int n;

      vt[0] = '{4'b1111, 4'b1000, 2'd3};
      vt[1] = '{4'b0110, 4'b0010, 2'd1};
      vt[2] = '{4'b0011, 4'b0001, 2'd0};
      vt[3] = '{4'b1001, 4'b1000, 2'd3};
      vt[4] = '{4'b1000, 4'b1000, 2'd3};
      vt[5] = '{4'b0101, 4'b0001, 2'd0};
      vt[6] = '{4'b0101, 4'b0100, 2'd2};

      // reset state
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_id", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
      cyc(2);
      rst = 1'b1;
      cyc(1);

      // latency: SYNC_STAGES+1 edges from req change to grant
      req = 4'b0100;
      push(4'b0100, 2'd2);
      cyc(2);
      chk("lat_early", grant, 0);
      cyc(1);
      chk("lat_grant", grant, 4'b0100);
      chk("lat_id", grant_id, 2);
      chk("lat_busy", busy, 1);
      release_owner("lat");
      chk("lat_id_kept", grant_id, 2);

      // round-robin vectors, pointer carried from entry to entry
      for (int i = 0; i < 7; i++) begin
         req = vt[i].req;
         push(vt[i].g, vt[i].id);
         wait_busy("vec_busy");
         chk("vec_grant", grant, vt[i].g);
         chk("vec_id", grant_id, vt[i].id);
         release_owner("vec");
      end

      // all four requesting from reset: strict rotation
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(1);
      req = 4'b1111;
      push(4'b0001, 2'd0);
      push(4'b0010, 2'd1);
      push(4'b0100, 2'd2);
      push(4'b1000, 2'd3);
      push(4'b0001, 2'd0);
      for (int i = 0; i < 5; i++) begin
         wait_busy("rr_busy");
         cyc(2);
         if (i == 4) req = '0;
         done = 1'b1;
         cyc(1);
         done = 1'b0;
         chk("rr_gap_grant", grant, 0);
         chk("rr_gap_busy", busy, 0);
      end
      cyc(3);

      // owner drops its request and another appears: grant is held until done
      req = 4'b0010;
      push(4'b0010, 2'd1);
      wait_busy("hold_busy");
      req = 4'b1000;
      cyc(5);
      chk("hold_grant", grant, 4'b0010);
      chk("hold_busy2", busy, 1);
      push(4'b1000, 2'd3);
      done = 1'b1;
      cyc(1);
      done = 1'b0;
      chk("hold_rel", grant, 0);
      wait_busy("hold_next_busy");
      chk("hold_next", grant, 4'b1000);
      release_owner("hold");

      // done while idle does nothing
      done = 1'b1;
      cyc(3);
      done = 1'b0;
      chk("idle_done_grant", grant, 0);
      chk("idle_done_busy", busy, 0);
      cyc(1);
      chk("idle_done_busy2", busy, 0);

      // async reset mid-grant
      req = 4'b0001;
      push(4'b0001, 2'd0);
      wait_busy("ar_busy");
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("ar_grant", grant, 0);
      chk("ar_busy", busy, 0);
      req = '0;
      cyc(2);
      rst = 1'b1;
      cyc(3);
      req = 4'b1111;
      push(4'b0001, 2'd0);
      wait_busy("ar_next_busy");
      chk("ar_next", grant, 4'b0001);
      release_owner("ar");

      // no done at all
      req = 4'b0001;
      push(4'b0001, 2'd0);
      wait_busy("to_busy");
`ifdef ARB_TIMEOUT_EN
      n = 0;
      while (!timeout && n < 40) begin
         @(negedge clk);
         n++;
      end
      req = '0;
      chk("to_cycles", n, 16);
      chk("to_grant_during", grant, 4'b0001);
      cyc(1);
      chk("to_pulse_end", timeout, 0);
      chk("to_grant_after", grant, 0);
      cyc(4);
`else
      hold_ok = 1'b1;
      n = 0;
      repeat (110) begin
         @(negedge clk);
         if (grant != 4'b0001 || timeout) hold_ok = 1'b0;
         n++;
      end
      chk("noto_hold", hold_ok, 1);
      chk("noto_timeout", timeout, 0);
      release_owner("noto");
`endif

      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
